// File: rtl/ssa_fold_engine.sv
// Streaming constant folder: one binary-op record in, one fold verdict out,
// in input order, through a small output FIFO. Divides run bit-serially.
module ssa_fold_engine #(
  parameter int WIDTH     = 64,
  parameter int ID_W      = 20,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [ID_W-1:0]  in_id,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_const,
  input  logic             in_b_const,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic             out_folded,
  output logic [WIDTH-1:0] out_result,
  output logic [31:0]      fold_count
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int EW = ID_W + 1 + WIDTH;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
  localparam logic [PW:0]      FULL_V = (PW+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_SDIV, OP_SREM, OP_AND, OP_OR, OP_XOR,
    OP_SHL, OP_LSHR, OP_ASHR, OP_EQ, OP_NE, OP_SLT, OP_RSV14, OP_RSV15
  } op_t;

  state_t state_q, state_d;
  op_t    op;

  logic             cmb_ok, cmb_div;
  logic [WIDTH-1:0] cmb_res;
  logic signed [WIDTH-1:0] sa, sb;

  // divider datapath: quo_q starts as |a| and fills with quotient bits
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic [WIDTH:0]   rem_sh, diff;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q, rem_op_q;
  logic [ID_W-1:0]  id_q;

  // output FIFO
  logic [EW-1:0]    mem_q [OUT_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_fifo_q;
  logic             full, accept, start_div, push, pop;
  logic [ID_W-1:0]  push_id;
  logic             push_fold;
  logic [WIDTH-1:0] push_res;
  logic [EW-1:0]    head;
  logic [31:0]      fold_q;

  assign op = op_t'(in_op);
  assign sa = in_a;
  assign sb = in_b;

  // single-cycle fold verdict for the record on the input port
  always_comb begin
    cmb_ok  = in_a_const && in_b_const;
    cmb_div = 1'b0;
    cmb_res = '0;
    case (op)
      OP_ADD:  cmb_res = in_a + in_b;
      OP_SUB:  cmb_res = in_a - in_b;
      OP_MUL:  cmb_res = in_a * in_b;
      OP_SDIV, OP_SREM: begin
        cmb_div = 1'b1;
        if (in_b == '0 || (in_a == INT_MIN && in_b == '1)) cmb_ok = 1'b0;
      end
      OP_AND:  cmb_res = in_a & in_b;
      OP_OR:   cmb_res = in_a | in_b;
      OP_XOR:  cmb_res = in_a ^ in_b;
      OP_SHL:  if (in_b >= WIDTH_V) cmb_ok = 1'b0; else cmb_res = in_a << in_b;
      OP_LSHR: if (in_b >= WIDTH_V) cmb_ok = 1'b0; else cmb_res = in_a >> in_b;
      OP_ASHR: if (in_b >= WIDTH_V) cmb_ok = 1'b0; else cmb_res = sa >>> in_b;
      OP_EQ:   cmb_res = WIDTH'(in_a == in_b);
      OP_NE:   cmb_res = WIDTH'(in_a != in_b);
      OP_SLT:  cmb_res = WIDTH'(sa < sb);
      default: cmb_ok = 1'b0;
    endcase
    if (!cmb_ok) cmb_res = '0;
  end

  assign full      = (cnt_fifo_q == FULL_V);
  assign accept    = in_valid && in_ready;
  assign start_div = accept && cmb_div && cmb_ok;
  assign pop       = out_valid && out_ready;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state, handshake and push selection
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    push      = 1'b0;
    push_id   = in_id;
    push_fold = cmb_ok;
    push_res  = cmb_res;
    case (state_q)
      S_IDLE: begin
        in_ready = rst_n && !full;
        if (start_div)   state_d = S_DIV;
        else if (accept) push = 1'b1;
      end
      S_DIV: if (cnt_q == LAST_BIT) state_d = S_FIX;
      S_FIX: begin
        push      = 1'b1;
        push_id   = id_q;
        push_fold = 1'b1;
        if (rem_op_q) push_res = neg_rem_q ? ('0 - rem_q) : rem_q;
        else          push_res = neg_quo_q ? ('0 - quo_q) : quo_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // one restoring-division step
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // divider operand latch and iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_div) begin
      quo_q     <= in_a[WIDTH-1] ? ('0 - in_a) : in_a;
      dvs_q     <= in_b[WIDTH-1] ? ('0 - in_b) : in_b;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
      neg_rem_q <= in_a[WIDTH-1];
      rem_op_q  <= (op == OP_SREM);
      id_q      <= in_id;
    end else if (state_q == S_DIV) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {push_id, push_fold, push_res};
  end

  // FIFO pointers, occupancy and folded-record counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_fifo_q <= '0;
      fold_q     <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop)      cnt_fifo_q <= cnt_fifo_q + (PW+1)'(1);
      else if (pop && !push) cnt_fifo_q <= cnt_fifo_q - (PW+1)'(1);
      if (push && push_fold && fold_q != '1) fold_q <= fold_q + 32'd1;
    end
  end

  // head is masked when empty so a drained or reset FIFO presents zeros
  assign out_valid  = (cnt_fifo_q != '0);
  assign head       = out_valid ? mem_q[rd_q] : '0;
  assign out_id     = head[EW-1 -: ID_W];
  assign out_folded = head[WIDTH];
  assign out_result = head[WIDTH-1:0];
  assign fold_count = fold_q;
endmodule

// File: tb/tb_ssa_fold_engine.sv
// Bench for ssa_fold_engine: four instances at WIDTH 8/16/32/64 sharing clock
// and reset, a vector table, hand sequences and a random run vs. a model.
module tb_ssa_fold_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        vld [4], rdy [4], ov [4], ordy [4], ofold [4];
  logic [3:0]  op [4];
  logic [63:0] a [4], b [4], ores [4];
  logic        ac [4], bc [4];
  logic [19:0] id [4], oid [4];
  logic [31:0] fc [4];

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [(8<<g)-1:0] r;
    ssa_fold_engine #(.WIDTH(8 << g), .ID_W(20), .OUT_DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vld[g]), .in_ready(rdy[g]),
      .in_op(op[g]), .in_id(id[g]),
      .in_a(a[g][(8<<g)-1:0]), .in_b(b[g][(8<<g)-1:0]),
      .in_a_const(ac[g]), .in_b_const(bc[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .out_id(oid[g]), .out_folded(ofold[g]),
      .out_result(r), .fold_count(fc[g])
    );
    assign ores[g] = 64'(r);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] x, input int w);
    return longint'(x << (64 - w)) >>> (64 - w);
  endfunction

  // reference: fold rules applied to w-bit two's-complement values
  function automatic void model(input int w, input logic [3:0] o,
                                input logic [63:0] ai, input logic [63:0] bi,
                                input logic ca, input logic cb,
                                output logic f, output logic [63:0] r);
    logic [63:0] m, x, y;
    longint s, t;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = ai & m; y = bi & m;
    s = sx(x, w); t = sx(y, w);
    f = ca && cb;
    r = 64'd0;
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x * y;
      4'd3, 4'd4:
        if (t == 0 || (s == -(longint'(1) << (w - 1)) && t == -1)) f = 1'b0;
        else r = (o == 4'd3) ? 64'(s / t) : 64'(s % t);
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = x ^ y;
      4'd8:  if (y >= 64'(w)) f = 1'b0; else r = x << y;
      4'd9:  if (y >= 64'(w)) f = 1'b0; else r = x >> y;
      4'd10: if (y >= 64'(w)) f = 1'b0; else r = 64'(s >>> y);
      4'd11: r = 64'(x == y);
      4'd12: r = 64'(x != y);
      4'd13: r = 64'(s < t);
      default: f = 1'b0;
    endcase
    r = f ? (r & m) : 64'd0;
  endfunction

  // one record through an empty engine, consumer always ready
  task automatic run1(input int k, input logic [3:0] o, input logic [63:0] aa,
                      input logic [63:0] bb, input logic ca, input logic cb,
                      input logic [19:0] ii, input logic ef, input logic [63:0] er,
                      input int elat, input string nm);
    int n;
    logic busy_ok;
    logic [31:0] fc0;
    fc0 = fc[k];
    op[k] = o; a[k] = aa; b[k] = bb; ac[k] = ca; bc[k] = cb; id[k] = ii;
    ordy[k] = 1'b1; vld[k] = 1'b1;
    n = 0;
    while (!rdy[k] && n < 100) begin @(posedge clk); #1; n++; end
    chk({nm, " ready"}, 64'(rdy[k]), 64'd1);
    @(posedge clk); #1;
    vld[k] = 1'b0;
    a[k] = {$urandom, $urandom}; b[k] = {$urandom, $urandom};
    op[k] = 4'($urandom); id[k] = 20'($urandom);
    n = 1; busy_ok = 1'b1;
    while (!ov[k] && n < 200) begin
      if (rdy[k]) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(elat));
    chk({nm, " busy"}, 64'(busy_ok), 64'd1);
    chk({nm, " id"}, 64'(oid[k]), 64'(ii));
    chk({nm, " folded"}, 64'(ofold[k]), 64'(ef));
    chk({nm, " result"}, ores[k], er);
    chk({nm, " fold_count"}, 64'(fc[k]), 64'(fc0 + 32'(ef)));
    @(posedge clk); #1;
  endtask

  typedef struct {
    int k; logic [3:0] op; logic [63:0] a, b; logic ca, cb;
    logic ef; logic [63:0] er; int lat;
  } vec_t;
  vec_t tbl [22];

  initial begin
    tbl[0]  = '{3, 4'd0,  64'd7, 64'd5, 1'b1, 1'b1, 1'b1, 64'd12, 1};
    tbl[1]  = '{0, 4'd2,  64'h10, 64'h20, 1'b1, 1'b1, 1'b1, 64'h0, 1};
    tbl[2]  = '{0, 4'd1,  64'h0, 64'h1, 1'b1, 1'b1, 1'b1, 64'hFF, 1};
    tbl[3]  = '{0, 4'd13, 64'h80, 64'h1, 1'b1, 1'b1, 1'b1, 64'h1, 1};
    tbl[4]  = '{1, 4'd3,  64'hFFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFD, 18};
    tbl[5]  = '{1, 4'd4,  64'hFFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF, 18};
    tbl[6]  = '{1, 4'd3,  64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 64'h0, 1};
    tbl[7]  = '{1, 4'd3,  64'h8000, 64'hFFFF, 1'b1, 1'b1, 1'b0, 64'h0, 1};
    tbl[8]  = '{3, 4'd0,  64'd1, 64'd2, 1'b1, 1'b0, 1'b0, 64'h0, 1};
    tbl[9]  = '{3, 4'd8,  64'd1, 64'd64, 1'b1, 1'b1, 1'b0, 64'h0, 1};
    tbl[10] = '{3, 4'd8,  64'd1, 64'd63, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1};
    tbl[11] = '{0, 4'd10, 64'h80, 64'd7, 1'b1, 1'b1, 1'b1, 64'hFF, 1};
    tbl[12] = '{0, 4'd9,  64'h80, 64'd7, 1'b1, 1'b1, 1'b1, 64'h1, 1};
    tbl[13] = '{0, 4'd8,  64'd1, 64'd8, 1'b1, 1'b1, 1'b0, 64'h0, 1};
    tbl[14] = '{2, 4'd3,  64'h8000_0000, 64'd1, 1'b1, 1'b1, 1'b1, 64'h8000_0000, 34};
    tbl[15] = '{0, 4'd4,  64'h80, 64'd3, 1'b1, 1'b1, 1'b1, 64'hFE, 10};
    tbl[16] = '{3, 4'd11, 64'd5, 64'd5, 1'b1, 1'b1, 1'b1, 64'h1, 1};
    tbl[17] = '{3, 4'd12, 64'd5, 64'd5, 1'b1, 1'b1, 1'b1, 64'h0, 1};
    tbl[18] = '{0, 4'd14, 64'd1, 64'd1, 1'b1, 1'b1, 1'b0, 64'h0, 1};
    tbl[19] = '{0, 4'd7,  64'hF0, 64'h3C, 1'b1, 1'b1, 1'b1, 64'hCC, 1};
    tbl[20] = '{3, 4'd3,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 66};
    tbl[21] = '{3, 4'd4,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 66};

    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; ordy[k] = 1'b1; op[k] = '0; a[k] = '0; b[k] = '0;
      ac[k] = 1'b0; bc[k] = 1'b0; id[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("rst ready%0d", k), 64'(rdy[k]), 64'd0);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post-rst ready%0d", k), 64'(rdy[k]), 64'd1);
      chk($sformatf("post-rst valid%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("post-rst count%0d", k), 64'(fc[k]), 64'd0);
    end

    // directed vectors
    for (int i = 0; i < 22; i++)
      run1(tbl[i].k, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ca, tbl[i].cb,
           20'(100 + i), tbl[i].ef, tbl[i].er, tbl[i].lat, $sformatf("vec%0d", i));

    // randomized records against the model
    for (int i = 0; i < 200; i++) begin
      int k, w, lat;
      logic [3:0] o;
      logic [63:0] x, y, er;
      logic ca, cb, ef;
      k = $urandom_range(0, 3);
      w = 8 << k;
      o = 4'($urandom_range(0, 15));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) x = 64'd1 << (w - 1);
      case ($urandom_range(0, 7))
        0: y = 64'd0;
        1: y = '1;
        2: y = 64'($urandom_range(0, w + 1));
        3: y = 64'($urandom_range(1, 9));
        default: ;
      endcase
      ca = ($urandom_range(0, 9) != 0);
      cb = ($urandom_range(0, 9) != 0);
      model(w, o, x, y, ca, cb, ef, er);
      lat = (ef && (o == 4'd3 || o == 4'd4)) ? w + 2 : 1;
      run1(k, o, x, y, ca, cb, 20'($urandom), ef, er, lat, $sformatf("rnd%0d", i));
    end

    // back-pressure on the 64-bit instance: fill, stall, single pop, drain
    ordy[3] = 1'b0;
    op[3] = 4'd0; ac[3] = 1'b1; bc[3] = 1'b1; b[3] = 64'd1; vld[3] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      id[3] = 20'(10 + j); a[3] = 64'(j);
      @(posedge clk); #1;
    end
    id[3] = 20'd14; a[3] = 64'd4;
    chk("bp full ready", 64'(rdy[3]), 64'd0);
    @(posedge clk); #1;
    chk("bp still full", 64'(rdy[3]), 64'd0);
    chk("bp head hold", 64'(oid[3]), 64'd10);
    ordy[3] = 1'b1;
    @(posedge clk); #1;
    ordy[3] = 1'b0;
    chk("bp pop head", 64'(oid[3]), 64'd11);
    chk("bp ready again", 64'(rdy[3]), 64'd1);
    @(posedge clk); #1;
    vld[3] = 1'b0;
    chk("bp refull", 64'(rdy[3]), 64'd0);
    ordy[3] = 1'b1;
    for (int j = 1; j < 5; j++) begin
      chk($sformatf("bp drain id%0d", j), 64'(oid[3]), 64'(10 + j));
      chk($sformatf("bp drain res%0d", j), ores[3], 64'(j + 1));
      @(posedge clk); #1;
    end
    chk("bp empty", 64'(ov[3]), 64'd0);

    // reset in the middle of a 32-bit divide with two queued results
    ordy[2] = 1'b0;
    op[2] = 4'd0; a[2] = 64'd3; b[2] = 64'd4; ac[2] = 1'b1; bc[2] = 1'b1; vld[2] = 1'b1;
    id[2] = 20'd40; @(posedge clk); #1;
    id[2] = 20'd41; @(posedge clk); #1;
    op[2] = 4'd3; a[2] = 64'd100; b[2] = 64'd7; id[2] = 20'd42;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    chk("mid-div ready", 64'(rdy[2]), 64'd0);
    chk("mid-div queued", 64'(oid[2]), 64'd40);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("div-rst ready low", 64'(rdy[2]), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("div-rst valid", 64'(ov[2]), 64'd0);
    chk("div-rst count", 64'(fc[2]), 64'd0);
    chk("div-rst ready", 64'(rdy[2]), 64'd1);
    chk("div-rst id", 64'(oid[2]), 64'd0);
    chk("div-rst result", ores[2], 64'd0);
    run1(2, 4'd0, 64'd1, 64'd1, 1'b1, 1'b1, 20'd50, 1'b1, 64'd2, 1, "post-rst add");
    repeat (40) begin @(posedge clk); #1; end
    chk("no stray push", 64'(ov[2]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
